// File: rtl/rv_pkg.sv
// Shared fetch definitions: fetch FSM state encoding, instruction size,
// default reset PC and a target-alignment helper.
// Build option: FETCH_MISALIGN_TRAP_EN adds the FAULT state.
package rv_pkg;

    localparam int unsigned XLEN = 64;
    localparam int unsigned ILEN = 32;

    localparam logic [XLEN-1:0] INSTR_BYTES      = 64'd4;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 64'h0000_0000_0000_0000;

    // REQ  : request presented to instruction memory
    // WAIT : request accepted, waiting for the response
    // HOLD : instruction buffered, offered to the decode controller
    // FAULT: misaligned redirect trapped, fetching stopped until reset
    typedef enum logic [1:0] {
        FS_REQ   = 2'd0,
        FS_WAIT  = 2'd1,
`ifdef FETCH_MISALIGN_TRAP_EN
        FS_HOLD  = 2'd2,
        FS_FAULT = 2'd3
`else
        FS_HOLD  = 2'd2
`endif
    } fetch_state_t;

    // Clears the sub-instruction offset bits of a byte address.
    function automatic logic [XLEN-1:0] align_target(input logic [XLEN-1:0] addr);
        return addr & ~(INSTR_BYTES - 64'd1);
    endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter: resets to RESET_PC, loads a redirect target or advances
// by one instruction. Load has priority over increment. Addition wraps
// naturally at 2^64.
module pc_reg
    import rv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_i,
    input  logic [XLEN-1:0] load_addr_i,
    input  logic            inc_i,
    output logic [XLEN-1:0] pc_o
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;

    // Next PC selection.
    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = load_addr_i;
        end else if (inc_i) begin
            pc_d = pc_q + INSTR_BYTES;
        end
    end

    // PC state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch unit: requests a word at pc, buffers
// the response, and offers it to the decode controller until consumed.
// The consume handshake is the only point where jump/jump_target are used.
// Build option: FETCH_MISALIGN_TRAP_EN traps misaligned redirects into a
// sticky FAULT state (misalign_fault port); without it, redirect targets
// are force-aligned to 4 bytes.
module fetch_unit
    import rv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [ILEN-1:0] imem_rsp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [ILEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    input  logic            jump,
    input  logic [XLEN-1:0] jump_target
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic            misalign_fault
`endif
);

    fetch_state_t    state_q;
    logic            req_valid_q;
    logic            instr_valid_q;
    logic [ILEN-1:0] instr_q;
    logic [XLEN-1:0] instr_pc_q;
    logic [XLEN-1:0] pc;
    logic            handshake;
    logic            target_misaligned;
    logic            pc_load;
    logic            pc_inc;

    // instr_valid_q is set exactly while in HOLD, so it qualifies the handshake.
    assign handshake = instr_valid_q & instr_ready;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic fault_q;
    assign target_misaligned = jump & (jump_target[1:0] != 2'b00);
    assign misalign_fault    = fault_q;
`else
    assign target_misaligned = 1'b0;
`endif

    assign pc_load = handshake & jump & ~target_misaligned;
    assign pc_inc  = handshake & ~jump;

    pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk         (clk),
        .rst         (rst),
        .load_i      (pc_load),
        .load_addr_i (align_target(jump_target)),
        .inc_i       (pc_inc),
        .pc_o        (pc)
    );

    // Fetch FSM with registered handshake outputs and instruction buffer.
    // req_valid_q lags entry into REQ by one cycle only right after reset,
    // so the request is never visible while rst is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= FS_REQ;
            req_valid_q   <= 1'b0;
            instr_valid_q <= 1'b0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
            fault_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                FS_REQ: begin
                    if (req_valid_q && imem_req_ready) begin
                        req_valid_q <= 1'b0;
                        state_q     <= FS_WAIT;
                    end else begin
                        req_valid_q <= 1'b1;
                    end
                end
                FS_WAIT: begin
                    if (imem_rsp_valid) begin
                        instr_q       <= imem_rsp_data;
                        instr_pc_q    <= pc;
                        instr_valid_q <= 1'b1;
                        state_q       <= FS_HOLD;
                    end
                end
                FS_HOLD: begin
                    if (instr_ready) begin
                        instr_valid_q <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
                        if (target_misaligned) begin
                            fault_q <= 1'b1;
                            state_q <= FS_FAULT;
                        end else begin
                            req_valid_q <= 1'b1;
                            state_q     <= FS_REQ;
                        end
`else
                        req_valid_q <= 1'b1;
                        state_q     <= FS_REQ;
`endif
                    end
                end
`ifdef FETCH_MISALIGN_TRAP_EN
                FS_FAULT: begin
                    state_q <= FS_FAULT;
                end
`endif
                default: begin
                    req_valid_q   <= 1'b0;
                    instr_valid_q <= 1'b0;
                    state_q       <= FS_REQ;
                end
            endcase
        end
    end

    assign imem_req_valid = req_valid_q;
    assign imem_req_addr  = pc;
    assign instr_valid    = instr_valid_q;
    assign instr          = instr_q;
    assign instr_pc       = instr_pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit. The bench plays instruction memory and
// decode controller, drives random stalls and noise, and predicts every fetch
// address and buffered word from a simple architectural PC model.
module tb_fetch_unit;

    localparam logic [63:0] RESET_PC = 64'h0;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [63:0] instr_pc;
    logic        jump;
    logic [63:0] jump_target;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        misalign_fault;
`endif

    int          vectors     = 0;
    int          miscompares = 0;
    int          cyc         = 0;
    logic [63:0] exp_pc;

    fetch_unit #(
        .RESET_PC (RESET_PC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .jump           (jump),
        .jump_target    (jump_target)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .misalign_fault (misalign_fault)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Memory contents: an arbitrary but fixed word per address.
    function automatic logic [31:0] mem_word(input logic [63:0] a);
        logic [31:0] lo;
        lo = a[33:2];
        return (lo * 32'h9E37_79B1) ^ a[63:32] ^ 32'h0000_0013;
    endfunction

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    task automatic idle_inputs();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        instr_ready    = 1'b0;
        jump           = 1'b0;
        jump_target    = 64'h0;
    endtask

    // One complete fetch with the given stall lengths, ending in a consume
    // handshake carrying jmp/tgt. Returns the cycle the request was seen.
    task automatic do_fetch(input int req_wait, input int rsp_wait, input int hold_wait,
                            input logic jmp, input logic [63:0] tgt, output int req_cyc);
        int          n;
        logic [31:0] w;
        n = 0;
        while (imem_req_valid !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        req_cyc = cyc;
        vectors++;
        if (imem_req_valid !== 1'b1) begin
            $display("FAIL req_timeout: imem_req_valid=%b, required 1", imem_req_valid);
            miscompares++;
        end
        vectors++;
        if (imem_req_addr !== exp_pc) begin
            $display("FAIL req_addr: got %h, required %h", imem_req_addr, exp_pc);
            miscompares++;
        end
        repeat (req_wait) begin
            imem_req_ready = 1'b0;
            imem_rsp_valid = 1'($urandom_range(0, 1));
            imem_rsp_data  = $urandom;
            instr_ready    = 1'($urandom_range(0, 1));
            jump           = 1'($urandom_range(0, 1));
            jump_target    = rand64();
            @(negedge clk);
            vectors++;
            if (imem_req_valid !== 1'b1 || imem_req_addr !== exp_pc) begin
                $display("FAIL req_stall: valid=%b addr=%h, required 1 %h",
                         imem_req_valid, imem_req_addr, exp_pc);
                miscompares++;
            end
        end
        idle_inputs();
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        vectors++;
        if (imem_req_valid !== 1'b0) begin
            $display("FAIL req_drop: imem_req_valid=%b, required 0", imem_req_valid);
            miscompares++;
        end
        repeat (rsp_wait) begin
            instr_ready = 1'($urandom_range(0, 1));
            jump        = 1'($urandom_range(0, 1));
            jump_target = rand64();
            @(negedge clk);
            vectors++;
            if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0) begin
                $display("FAIL wait_idle: req_valid=%b instr_valid=%b, required 0 0",
                         imem_req_valid, instr_valid);
                miscompares++;
            end
        end
        idle_inputs();
        w = mem_word(exp_pc);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = w;
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        vectors++;
        if (instr_valid !== 1'b1 || instr !== w || instr_pc !== exp_pc) begin
            $display("FAIL capture: valid=%b instr=%h pc=%h, required 1 %h %h",
                     instr_valid, instr, instr_pc, w, exp_pc);
            miscompares++;
        end
        repeat (hold_wait) begin
            instr_ready    = 1'b0;
            imem_rsp_valid = 1'($urandom_range(0, 1));
            imem_rsp_data  = $urandom;
            jump           = 1'($urandom_range(0, 1));
            jump_target    = rand64();
            @(negedge clk);
            vectors++;
            if (instr_valid !== 1'b1 || instr !== w || instr_pc !== exp_pc ||
                imem_req_valid !== 1'b0) begin
                $display("FAIL hold_stable: valid=%b instr=%h pc=%h req=%b, required 1 %h %h 0",
                         instr_valid, instr, instr_pc, imem_req_valid, w, exp_pc);
                miscompares++;
            end
        end
        idle_inputs();
        instr_ready = 1'b1;
        jump        = jmp;
        jump_target = tgt;
        @(negedge clk);
        idle_inputs();
        jump_target = rand64();
        vectors++;
        if (instr_valid !== 1'b0) begin
            $display("FAIL consume: instr_valid=%b, required 0", instr_valid);
            miscompares++;
        end
`ifdef FETCH_MISALIGN_TRAP_EN
        if (jmp && tgt[1:0] != 2'b00) begin
            vectors++;
            if (misalign_fault !== 1'b1 || imem_req_valid !== 1'b0) begin
                $display("FAIL fault_entry: fault=%b req_valid=%b, required 1 0",
                         misalign_fault, imem_req_valid);
                miscompares++;
            end
            return;
        end
`endif
        // Architectural PC rule: redirect to the word-aligned target, else next word.
        if (jmp) exp_pc = tgt & ~64'h3;
        else     exp_pc = exp_pc + 64'd4;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0 ||
            instr !== 32'h0 || instr_pc !== 64'h0) begin
            $display("FAIL reset_state: req=%b ivalid=%b instr=%h ipc=%h, required 0 0 0 0",
                     imem_req_valid, instr_valid, instr, instr_pc);
            miscompares++;
        end
`ifdef FETCH_MISALIGN_TRAP_EN
        vectors++;
        if (misalign_fault !== 1'b0) begin
            $display("FAIL reset_fault: misalign_fault=%b, required 0", misalign_fault);
            miscompares++;
        end
`endif
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC) begin
            $display("FAIL reset_release: req=%b addr=%h, required 1 %h",
                     imem_req_valid, imem_req_addr, RESET_PC);
            miscompares++;
        end
        exp_pc = RESET_PC;
    endtask

    task automatic test_throughput();
        int c0, c1, c2, c3;
        do_fetch(0, 0, 0, 1'b0, 64'h0, c0);
        do_fetch(0, 0, 0, 1'b0, 64'h0, c1);
        do_fetch(0, 0, 0, 1'b0, 64'h0, c2);
        do_fetch(0, 0, 0, 1'b0, 64'h0, c3);
        vectors++;
        if (c1 - c0 != 3 || c2 - c1 != 3 || c3 - c2 != 3) begin
            $display("FAIL throughput: spacing %0d %0d %0d, required 3 3 3",
                     c1 - c0, c2 - c1, c3 - c2);
            miscompares++;
        end
    endtask

    task automatic test_hold_stall();
        int c;
        do_fetch(1, 2, 5, 1'b0, 64'h0, c);
    endtask

    task automatic test_jump();
        int c;
        do_fetch(2, 1, 3, 1'b1, 64'h100, c);
        do_fetch(0, 0, 0, 1'b0, 64'h0, c);
    endtask

    task automatic test_wrap();
        int c;
        do_fetch(0, 0, 1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, c);
        do_fetch(0, 1, 0, 1'b0, 64'h0, c);
        do_fetch(0, 0, 0, 1'b0, 64'h0, c);
    endtask

    task automatic test_random();
        int          c;
        logic        j;
        logic [63:0] t;
        for (int i = 0; i < 40; i++) begin
            j = ($urandom_range(0, 3) == 0);
            t = rand64();
`ifdef FETCH_MISALIGN_TRAP_EN
            t = t & ~64'h3;
`endif
            do_fetch(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 3)), j, t, c);
        end
    endtask

    task automatic test_reset_mid_wait();
        int c;
        do_fetch(0, 0, 0, 1'b1, 64'h2000, c);
        idle_inputs();
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0 || instr !== 32'h0) begin
            $display("FAIL midwait_reset: req=%b ivalid=%b instr=%h, required 0 0 0",
                     imem_req_valid, instr_valid, instr);
            miscompares++;
        end
        rst            = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0000_0013;
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        vectors++;
        if (instr_valid !== 1'b0 || instr !== 32'h0 ||
            imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC) begin
            $display("FAIL late_rsp: ivalid=%b instr=%h req=%b addr=%h, required 0 0 1 %h",
                     instr_valid, instr, imem_req_valid, imem_req_addr, RESET_PC);
            miscompares++;
        end
        exp_pc = RESET_PC;
        do_fetch(0, 0, 0, 1'b0, 64'h0, c);
        do_fetch(1, 1, 1, 1'b0, 64'h0, c);
    endtask

    task automatic test_misalign();
        int c;
        do_fetch(0, 0, 1, 1'b1, 64'h102, c);
`ifdef FETCH_MISALIGN_TRAP_EN
        repeat (6) begin
            imem_req_ready = 1'b1;
            imem_rsp_valid = 1'($urandom_range(0, 1));
            instr_ready    = 1'b1;
            @(negedge clk);
            vectors++;
            if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0 || misalign_fault !== 1'b1) begin
                $display("FAIL fault_sticky: req=%b ivalid=%b fault=%b, required 0 0 1",
                         imem_req_valid, instr_valid, misalign_fault);
                miscompares++;
            end
        end
        test_reset();
        do_fetch(0, 0, 0, 1'b0, 64'h0, c);
`else
        do_fetch(0, 0, 0, 1'b0, 64'h0, c);
        vectors++;
        if (instr_pc !== 64'h100) begin
            $display("FAIL misalign_forced: instr_pc=%h, required %h", instr_pc, 64'h100);
            miscompares++;
        end
`endif
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        exp_pc = RESET_PC;
        test_reset();
        test_throughput();
        test_hold_stall();
        test_jump();
        test_wrap();
        test_random();
        test_reset_mid_wait();
        test_misalign();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
